// File: rtl/div_sequencer.sv
// div_sequencer: front end for the multi-cycle divider used by the EX stage.
// It accepts DIV/DIVU/REM/REMU requests, launches the divider and returns the
// quotient or remainder. A one-entry cache answers the paired op for the same
// operands without a new launch. It also handles flush and the watchdog.
module div_sequencer #(
  parameter int CACHE_EN   = 1,
  parameter int MAX_CYCLES = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy,
  output logic        timeout_err,
  output logic        div_start,
  output logic [2:0]  div_op,
  output logic [31:0] dividend,
  output logic [31:0] divisor,
  input  logic [31:0] quotient,
  input  logic [31:0] remainder,
  input  logic        div_done
);

  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    op_reg, op_next;
  logic [31:0]   rs1_reg, rs1_next;
  logic [31:0]   rs2_reg, rs2_next;
  logic [31:0]   data_reg, data_next;
  logic          err_reg, err_next;
  logic          tmo_reg, tmo_next;
  logic          c_valid_reg, c_valid_next;
  logic [31:0]   c_rs1_reg, c_rs1_next;
  logic [31:0]   c_rs2_reg, c_rs2_next;
  logic          c_uns_reg, c_uns_next;
  logic [31:0]   c_quo_reg, c_quo_next;
  logic [31:0]   c_rem_reg, c_rem_next;

  logic          accept;
  logic          hit;
  logic [CW-1:0] cnt_inc;
  logic          limit;

  assign req_ready   = (state_reg == IDLE) && !flush;
  assign busy        = (state_reg != IDLE);
  assign resp_valid  = (state_reg == RESP);
  assign div_start   = (state_reg == LAUNCH);
  assign div_op      = op_reg;
  assign dividend    = rs1_reg;
  assign divisor     = rs2_reg;
  assign resp_data   = data_reg;
  assign resp_err    = err_reg;
  assign timeout_err = tmo_reg;

  assign accept  = req_valid && req_ready;
  // The cache holds both quotient and remainder, so only signedness must match.
  assign hit     = (CACHE_EN != 0) && c_valid_reg && (req_rs1 == c_rs1_reg) &&
                   (req_rs2 == c_rs2_reg) && (req_op[0] == c_uns_reg);
  assign cnt_inc = cnt_reg + 1'b1;
  // Fires on the MAX_CYCLES-th cycle spent waiting after the launch pulse.
  assign limit   = (cnt_inc == CW'(MAX_CYCLES));

  // Next-state and datapath updates; everything holds unless a case changes it.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    op_next      = op_reg;
    rs1_next     = rs1_reg;
    rs2_next     = rs2_reg;
    data_next    = data_reg;
    err_next     = err_reg;
    tmo_next     = tmo_reg;
    c_valid_next = c_valid_reg;
    c_rs1_next   = c_rs1_reg;
    c_rs2_next   = c_rs2_reg;
    c_uns_next   = c_uns_reg;
    c_quo_next   = c_quo_reg;
    c_rem_next   = c_rem_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_next  = req_op;
          rs1_next = req_rs1;
          rs2_next = req_rs2;
          if (hit) begin
            data_next  = req_op[1] ? c_rem_reg : c_quo_reg;
            err_next   = 1'b0;
            state_next = RESP;
          end else begin
            state_next = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        cnt_next   = '0;
        state_next = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        cnt_next = cnt_inc;
        if (div_done) begin
          // A flush in the completion cycle discards the result entirely.
          if (flush) begin
            state_next = IDLE;
          end else begin
            data_next    = op_reg[1] ? remainder : quotient;
            err_next     = 1'b0;
            c_valid_next = 1'b1;
            c_rs1_next   = rs1_reg;
            c_rs2_next   = rs2_reg;
            c_uns_next   = op_reg[0];
            c_quo_next   = quotient;
            c_rem_next   = remainder;
            state_next   = RESP;
          end
        end else if (limit) begin
          tmo_next     = 1'b1;
          c_valid_next = 1'b0;
          if (flush) begin
            state_next = IDLE;
          end else begin
            data_next  = 32'hFFFF_FFFF;
            err_next   = 1'b1;
            state_next = RESP;
          end
        end else if (flush) begin
          state_next = DRAIN;
        end
      end
      RESP: begin
        if (flush || resp_ready) begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        // The divider is still busy with the killed op; let it finish silently.
        cnt_next = cnt_inc;
        if (div_done) begin
          state_next = IDLE;
        end else if (limit) begin
          tmo_next     = 1'b1;
          c_valid_next = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      op_reg      <= '0;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      data_reg    <= '0;
      err_reg     <= 1'b0;
      tmo_reg     <= 1'b0;
      c_valid_reg <= 1'b0;
      c_rs1_reg   <= '0;
      c_rs2_reg   <= '0;
      c_uns_reg   <= 1'b0;
      c_quo_reg   <= '0;
      c_rem_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      op_reg      <= op_next;
      rs1_reg     <= rs1_next;
      rs2_reg     <= rs2_next;
      data_reg    <= data_next;
      err_reg     <= err_next;
      tmo_reg     <= tmo_next;
      c_valid_reg <= c_valid_next;
      c_rs1_reg   <= c_rs1_next;
      c_rs2_reg   <= c_rs2_next;
      c_uns_reg   <= c_uns_next;
      c_quo_reg   <= c_quo_next;
      c_rem_reg   <= c_rem_next;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed scenarios plus randomized traffic, checked every
// cycle against a timestamp-based transaction model and a stub divider.
module tb_div_sequencer;
  localparam int MAXC = 40;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;
  localparam int P_IDLE = 0, P_COMP = 1, P_REPLY = 2, P_DRAIN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, req_valid, req_ready, flush, resp_valid, resp_ready, resp_err;
  logic busy, timeout_err, div_start, div_done;
  logic [2:0] req_op, div_op;
  logic [31:0] req_rs1, req_rs2, resp_data, dividend, divisor, quotient, remainder;

  div_sequencer #(.CACHE_EN(1), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy), .timeout_err(timeout_err),
    .div_start(div_start), .div_op(div_op), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .div_done(div_done)
  );

  int checks = 0, errors = 0;
  // model state: phase of the current transaction plus its launch timestamp
  int ph, cyc, t_launch;
  logic [2:0] m_op;
  logic [31:0] m_a, m_b, m_data;
  logic m_err, m_tmo;
  logic c_v, c_u;
  logic [31:0] c_a, c_b, c_q, c_r;
  // stub divider
  int done_at = -1, stub_lat = 3, spur_pct = 0, n_starts = 0;
  bit rand_stub = 0;
  logic [31:0] s_q, s_r;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // RISC-V M-extension division semantics
  task automatic ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a; r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b; r = a % b;
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE; m_op = '0; m_a = '0; m_b = '0; m_data = '0; m_err = 0; m_tmo = 0;
    c_v = 0; c_u = 0; c_a = '0; c_b = '0; c_q = '0; c_r = '0;
  endtask

  // One clock cycle: compare outputs, schedule the stub, advance the model.
  task automatic step();
    logic e_ready, e_start;
    int lat, rr;
    #1;
    e_ready = (ph == P_IDLE) && !flush;
    e_start = (ph == P_COMP) && (cyc == t_launch);
    check("req_ready", req_ready, e_ready);
    check("busy", busy, ph != P_IDLE);
    check("resp_valid", resp_valid, ph == P_REPLY);
    check("div_start", div_start, e_start);
    check("resp_data", resp_data, m_data);
    check("resp_err", resp_err, m_err);
    check("timeout_err", timeout_err, m_tmo);
    check("div_op", div_op, m_op);
    check("dividend", dividend, m_a);
    check("divisor", divisor, m_b);
    if (div_start) n_starts++;
    if (e_start) begin
      if (rand_stub) begin
        rr = $urandom_range(99);
        lat = (rr < 5) ? 0 : (rr < 10) ? MAXC + 5 : $urandom_range(10, 1);
      end else lat = stub_lat;
      done_at = (lat > 0) ? cyc + lat : -1;
      ref_div(m_op, m_a, m_b, s_q, s_r);
    end
    if (!rst) model_reset();
    else begin
      case (ph)
        P_IDLE: if (req_valid && e_ready) begin
          m_op = req_op; m_a = req_rs1; m_b = req_rs2;
          if (c_v && c_a == req_rs1 && c_b == req_rs2 && c_u == req_op[0]) begin
            m_data = req_op[1] ? c_r : c_q; m_err = 0; ph = P_REPLY;
          end else begin
            t_launch = cyc + 1; ph = P_COMP;
          end
        end
        P_COMP: if (cyc == t_launch) begin
          if (flush) ph = P_DRAIN;
        end else if (div_done) begin
          if (flush) ph = P_IDLE;
          else begin
            m_data = m_op[1] ? remainder : quotient; m_err = 0;
            c_v = 1; c_a = m_a; c_b = m_b; c_u = m_op[0]; c_q = quotient; c_r = remainder;
            ph = P_REPLY;
          end
        end else if (cyc - t_launch == MAXC) begin
          m_tmo = 1; c_v = 0;
          if (flush) ph = P_IDLE;
          else begin m_data = 32'hFFFF_FFFF; m_err = 1; ph = P_REPLY; end
        end else if (flush) ph = P_DRAIN;
        P_REPLY: if (flush || resp_ready) ph = P_IDLE;
        P_DRAIN: if (div_done) ph = P_IDLE;
          else if (cyc - t_launch == MAXC) begin m_tmo = 1; c_v = 0; ph = P_IDLE; end
        default: ph = P_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
    if (done_at == cyc) begin
      div_done = 1; quotient = s_q; remainder = s_r; done_at = -1;
    end else if ((ph == P_IDLE || ph == P_REPLY) && $urandom_range(99) < spur_pct) begin
      div_done = 1; quotient = $urandom; remainder = $urandom;
    end else begin
      div_done = 0;
    end
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] data, output logic err,
                        output int t_acc, output int t_resp);
    req_valid = 1; req_op = op; req_rs1 = a; req_rs2 = b;
    t_acc = -1; t_resp = -1; data = '0; err = 0;
    for (int i = 0; i < 200 && t_acc < 0; i++) begin
      if (ph == P_IDLE && !flush) t_acc = cyc;
      step();
    end
    req_valid = 0;
    if (t_acc < 0) check("accept_bound", 0, 1);
    for (int i = 0; i < 200 && t_resp < 0; i++) begin
      if (resp_valid) t_resp = cyc; else step();
    end
    if (t_resp < 0) check("resp_bound", 0, 1);
    else begin
      data = resp_data; err = resp_err;
      resp_ready = 0;
      for (int i = 0; i < hold; i++) begin
        check("hold_valid", resp_valid, 1);
        check("hold_data", resp_data, data);
        check("hold_req_ready", req_ready, 0);
        step();
      end
      resp_ready = 1; step(); resp_ready = 0;
    end
  endtask

  logic [31:0] d;
  logic e;
  int ta, tr, s0, rv;
  logic [31:0] pool [8] = '{32'd100, 32'd7, 32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd3};
  logic [31:0] pa, pb;

  initial begin
    rst = 0; req_valid = 0; req_op = OP_DIV; req_rs1 = 0; req_rs2 = 0; flush = 0;
    resp_ready = 0; div_done = 0; quotient = 0; remainder = 0;
    model_reset(); cyc = 0; t_launch = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_div_start", div_start, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_dividend", dividend, 0);
    rst = 1;

    // DIV 100/7: miss, latency accept+5 with 3-cycle divider
    stub_lat = 3; s0 = n_starts;
    do_req(OP_DIV, 32'd100, 32'd7, 0, d, e, ta, tr);
    check("div100_7", d, 32'd14);
    check("div100_7_lat", tr - ta, 5);
    check("div100_7_starts", n_starts - s0, 1);
    // REM 100/7: cache hit, one cycle later, no launch
    s0 = n_starts;
    do_req(OP_REM, 32'd100, 32'd7, 0, d, e, ta, tr);
    check("rem_hit", d, 32'd2);
    check("rem_hit_lat", tr - ta, 1);
    check("rem_hit_starts", n_starts - s0, 0);
    // signedness distinguishes cache entries
    do_req(OP_DIV, 32'hFFFF_FFFF, 32'd2, 0, d, e, ta, tr);
    check("div_m1_2", d, 32'd0);
    s0 = n_starts;
    do_req(OP_DIVU, 32'hFFFF_FFFF, 32'd2, 0, d, e, ta, tr);
    check("divu_ff_2", d, 32'h7FFF_FFFF);
    check("divu_starts", n_starts - s0, 1);

    // flush three cycles into WAIT, divider still finishes later
    stub_lat = 10;
    req_valid = 1; req_op = OP_DIV; req_rs1 = 32'd20; req_rs2 = 32'd4;
    step(); req_valid = 0;
    for (int i = 0; i < 20 && cyc < t_launch + 3; i++) step();
    flush = 1; step(); flush = 0;
    rv = 0;
    for (int i = 0; i < 12; i++) begin rv += int'(resp_valid); step(); end
    check("flush_no_resp", rv, 0);
    check("flush_idle", busy, 0);
    stub_lat = 2;
    do_req(OP_DIV, 32'd9, 32'd3, 5, d, e, ta, tr);
    check("div9_3", d, 32'd3);

    // watchdog: divider never completes
    stub_lat = 0;
    do_req(OP_DIV, 32'd55, 32'd5, 0, d, e, ta, tr);
    check("tmo_data", d, 32'hFFFF_FFFF);
    check("tmo_err", e, 1);
    check("tmo_sticky", timeout_err, 1);
    check("tmo_lat", tr - ta, MAXC + 2);
    stub_lat = 2; s0 = n_starts;
    do_req(OP_DIV, 32'd9, 32'd3, 0, d, e, ta, tr);
    check("tmo_cache_inval", n_starts - s0, 1);

    // reset in the middle of WAIT
    do_req(OP_DIV, 32'd100, 32'd7, 0, d, e, ta, tr);
    stub_lat = 20;
    req_valid = 1; req_op = OP_DIV; req_rs1 = 32'd8; req_rs2 = 32'd2;
    step(); req_valid = 0;
    repeat (4) step();
    rst = 0; step(); rst = 1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tmo", timeout_err, 0);
    check("mid_rst_data", resp_data, 0);
    check("mid_rst_divisor", divisor, 0);
    stub_lat = 2; s0 = n_starts;
    do_req(OP_REM, 32'd100, 32'd7, 0, d, e, ta, tr);
    check("post_rst_rem", d, 32'd2);
    check("post_rst_miss", n_starts - s0, 1);

    // randomized traffic
    rand_stub = 1; spur_pct = 3; pa = 32'd100; pb = 32'd7;
    for (int i = 0; i < 2000; i++) begin
      req_valid = ($urandom_range(99) < 60);
      req_op = 3'b100 | 3'($urandom_range(3));
      if ($urandom_range(9) >= 4) begin
        pa = ($urandom_range(1) != 0) ? pool[$urandom_range(7)] : $urandom;
        pb = ($urandom_range(1) != 0) ? pool[$urandom_range(7)] : $urandom;
      end
      req_rs1 = pa; req_rs2 = pb;
      flush = ($urandom_range(99) < 3);
      resp_ready = ($urandom_range(99) < 60);
      rst = !($urandom_range(999) < 5);
      step();
    end
    req_valid = 0; flush = 0; resp_ready = 1; rst = 1; spur_pct = 0;
    repeat (100) step();
    check("final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
